// File: rtl/fifo_rd_pkg.sv
// Shared constants and index helper for the FIFO stream reader.
package fifo_rd_pkg;

  localparam int FIFO_RD_CNT_W     = 16;
  localparam int FIFO_RD_DEPTH_MIN = 2;
  localparam int FIFO_RD_DEPTH_MAX = 8;
  // Index width that covers the largest legal buffer
  localparam int FIFO_RD_IDX_MAX_W = 3;

  function automatic logic [FIFO_RD_IDX_MAX_W-1:0] buf_idx_next(
    input logic [FIFO_RD_IDX_MAX_W-1:0] idx,
    input int                           depth
  );
    logic [FIFO_RD_IDX_MAX_W-1:0] nxt;
    if (int'(idx) >= depth - 1) begin
      nxt = '0;
    end else begin
      nxt = idx + 1'b1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Circular output buffer for fifo_stream_reader: push at the tail, pop at the head,
// with an occupancy count the issue logic uses as credit.
module fifo_rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int BUF_DEPTH = 3,
  localparam int IDX_W    = $clog2(BUF_DEPTH),
  localparam int CNT_W    = $clog2(BUF_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0]     buf_reg [BUF_DEPTH];
  logic [IDX_W-1:0]     wr_idx_reg;
  logic [IDX_W-1:0]     wr_idx_next;
  logic [IDX_W-1:0]     rd_idx_reg;
  logic [IDX_W-1:0]     rd_idx_next;
  logic [CNT_W-1:0]     count_reg;
  logic [CNT_W-1:0]     count_next;
  logic [BUF_DEPTH-1:0] entry_we;
  logic                 pop_ok;

  assign head_valid = (count_reg != '0);
  assign head_data  = buf_reg[rd_idx_reg];
  assign count      = count_reg;
  // A pop against an empty buffer is ignored rather than corrupting the indices
  assign pop_ok     = pop && head_valid;

  for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_we
    assign entry_we[gi] = push && (wr_idx_reg == IDX_W'(gi));
  end

  always_comb begin
    wr_idx_next = wr_idx_reg;
    rd_idx_next = rd_idx_reg;
    count_next  = count_reg;
    if (push) begin
      wr_idx_next = IDX_W'(buf_idx_next(FIFO_RD_IDX_MAX_W'(wr_idx_reg), BUF_DEPTH));
    end
    if (pop_ok) begin
      rd_idx_next = IDX_W'(buf_idx_next(FIFO_RD_IDX_MAX_W'(rd_idx_reg), BUF_DEPTH));
    end
    case ({push, pop_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_reg[i] <= '0;
      end
      wr_idx_reg <= '0;
      rd_idx_reg <= '0;
      count_reg  <= '0;
    end else begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        if (entry_we[i]) begin
          buf_reg[i] <= push_data;
        end
      end
      wr_idx_reg <= wr_idx_next;
      rd_idx_reg <= rd_idx_next;
      count_reg  <= count_next;
    end
  end

  // Credit accounting upstream must never let a capture land in a full buffer
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && count_reg == CNT_W'(BUF_DEPTH)));

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO into a valid/ready stream via a credit-managed skid buffer.
// Optional handshake counter port xfer_count is enabled by defining FIFO_RD_STATS_EN.
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int BUF_DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_rd_en,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [FIFO_RD_CNT_W-1:0] xfer_count
`endif
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  if (BUF_DEPTH < FIFO_RD_DEPTH_MIN || BUF_DEPTH > FIFO_RD_DEPTH_MAX) begin : g_depth_check
    $error("fifo_stream_reader: BUF_DEPTH must be within 2..8");
  end

  logic             inflight_reg;
  logic             inflight_next;
  logic [CNT_W-1:0] count;
  logic [SUM_W-1:0] credit_used;
  logic             pop;

  // Issue depends only on registered state, so m_ready never reaches fifo_rd_en
  assign credit_used   = {1'b0, count} + SUM_W'(inflight_reg);
  assign fifo_rd_en    = !fifo_empty && (credit_used < SUM_W'(BUF_DEPTH));
  assign inflight_next = fifo_rd_en && !fifo_empty;
  assign pop           = m_valid && m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_reg <= 1'b0;
    end else begin
      inflight_reg <= inflight_next;
    end
  end

  fifo_rd_skid_buf #(
    .WIDTH     (WIDTH),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_skid_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (inflight_reg),
    .push_data  (fifo_dout),
    .pop        (pop),
    .head_valid (m_valid),
    .head_data  (m_data),
    .count      (count)
  );

`ifdef FIFO_RD_STATS_EN
  logic [FIFO_RD_CNT_W-1:0] xfer_count_reg;
  logic [FIFO_RD_CNT_W-1:0] xfer_count_next;

  assign xfer_count_next = pop ? xfer_count_reg + 1'b1 : xfer_count_reg;
  assign xfer_count      = xfer_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_count_reg <= '0;
    end else begin
      xfer_count_reg <= xfer_count_next;
    end
  end
`endif

endmodule
